stopwatch_lap_bcd: RTL

//  Parametrised stopwatch/countdown timer with lap-freeze display, driving six 7-seg digits (MM:SS:cc).

---
 rtl/stopwatch_lap_bcd.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_lap_bcd.sv
// rtl/stopwatch_lap_bcd.sv - stopwatch / countdown timer with lap freeze driving six 7-seg digits
// Purpose: MM:SS.cc up/down timer run from a one-cycle 1/100 s tick, with lap-freeze display.
// Ports:
//  clk, clr        clock and synchronous active-high clear
//  pow             enable level; low blocks start and pauses a running timer
//  str, pas, lap   active-low buttons (start/resume, pause, lap toggle), asynchronous to clk
//  dir, preset_min count direction (1 = down) and countdown start minutes, taken when leaving IDLE
//  HEX0..HEX5      registered 7-seg digits {g,f,e,d,c,b,a}: cs units .. minute tens
//  tick, of        1/100 s pulse while running; pulse on up-wrap or countdown expiry
//  running         high in RUN
//  lap_active      high while the display is frozen
`timescale 1ns/1ps
module stopwatch_lap_bcd #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int MAX_MIN        = 99,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       pow,
  input  logic       str,
  input  logic       pas,
  input  logic       lap,
  input  logic       dir,
  input  logic [6:0] preset_min,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       tick,
  output logic       of,
  output logic       running,
  output logic       lap_active
);
  localparam int DIV = CLK_HZ / 100;
  localparam int PW  = $clog2(DIV);
  localparam logic [7:0] MAX_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] presc;
  logic [7:0]    cs, sec, mins;
  logic [23:0]   snap, cnt_up, cnt_dn, shown;
  logic          dir_q, freeze;
  logic [3:0]    str_sh, pas_sh, lap_sh;
  logic          str_edge, pas_edge, lap_edge;
  logic          str_act, pas_act, lap_act;
  logic          presc_tc, tick_i, at_max, at_one, expire, start_ok, load_preset;
  logic [6:0]    preset_cl;
  logic [7:0]    preset_bcd;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return SEG_ACTIVE_LOW ? s : ~s;
  endfunction

  // Bits 0/1 synchronise; bits 2/3 form a registered falling-edge detector, so a
  // button first sampled low at edge N is acted on at edge N+3.
  always_ff @(posedge clk) begin
    if (clr) begin
      str_sh <= '1;
      pas_sh <= '1;
      lap_sh <= '1;
    end else begin
      str_sh <= {str_sh[2:0], str};
      pas_sh <= {pas_sh[2:0], pas};
      lap_sh <= {lap_sh[2:0], lap};
    end
  end

  assign str_edge = str_sh[3] & ~str_sh[2];
  assign pas_edge = pas_sh[3] & ~pas_sh[2];
  assign lap_edge = lap_sh[3] & ~lap_sh[2];

  // Only the highest-priority button edge of a cycle is acted on.
  assign pas_act = pas_edge;
  assign str_act = str_edge & ~pas_edge;
  assign lap_act = lap_edge & ~pas_edge & ~str_edge;

  assign preset_cl  = (preset_min > 7'(MAX_MIN)) ? 7'(MAX_MIN) : preset_min;
  assign preset_bcd = {4'(preset_cl / 7'd10), 4'(preset_cl % 7'd10)};

  assign presc_tc    = (presc == PW'(DIV - 1));
  assign tick_i      = (state == S_RUN) & presc_tc;
  assign at_max      = (cs == 8'h99) & (sec == 8'h59) & (mins == MAX_BCD);
  assign at_one      = (cs == 8'h01) & (sec == 8'h00) & (mins == 8'h00);
  assign expire      = tick_i & dir_q & at_one;
  // A zero countdown preset is not a valid start: the timer stays in IDLE.
  assign start_ok    = (state == S_IDLE) & str_act & pow & (~dir | (preset_cl != 7'd0));
  assign load_preset = start_ok & dir;

  always_comb begin
    cnt_up = {mins, sec, cs};
    if (cs != 8'h99) begin
      cnt_up[7:0] = bcd_inc(cs);
    end else begin
      cnt_up[7:0] = 8'h00;
      if (sec != 8'h59) begin
        cnt_up[15:8] = bcd_inc(sec);
      end else begin
        cnt_up[15:8]  = 8'h00;
        cnt_up[23:16] = (mins == MAX_BCD) ? 8'h00 : bcd_inc(mins);
      end
    end
  end

  // Never evaluated at 00:00.00: expiry stops the count one step earlier.
  always_comb begin
    cnt_dn = {mins, sec, cs};
    if (cs != 8'h00) begin
      cnt_dn[7:0] = bcd_dec(cs);
    end else begin
      cnt_dn[7:0] = 8'h99;
      if (sec != 8'h00) begin
        cnt_dn[15:8] = bcd_dec(sec);
      end else begin
        cnt_dn[15:8]  = 8'h59;
        cnt_dn[23:16] = bcd_dec(mins);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_ok) state_nx = S_RUN;
      S_RUN:   if (expire) state_nx = S_DONE;
               else if (pas_act || !pow) state_nx = S_PAUSE;
      S_PAUSE: if (str_act && pow) state_nx = S_RUN;
      S_DONE:  if (str_act && pow) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    running    = (state == S_RUN);
    tick       = tick_i;
    of         = tick_i & (dir_q ? at_one : at_max);
    lap_active = freeze;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      presc  <= '0;
      cs     <= 8'h00;
      sec    <= 8'h00;
      mins   <= 8'h00;
      dir_q  <= 1'b0;
      freeze <= 1'b0;
      snap   <= 24'h0;
    end else begin
      // Held outside RUN so a resume completes the interrupted period.
      if (state == S_RUN) presc <= presc_tc ? '0 : presc + 1'b1;
      if (start_ok) dir_q <= dir;
      if (load_preset) begin
        mins <= preset_bcd;
        sec  <= 8'h00;
        cs   <= 8'h00;
      end else if (state == S_DONE && str_act && pow) begin
        mins <= 8'h00;
        sec  <= 8'h00;
        cs   <= 8'h00;
      end else if (tick_i) begin
        {mins, sec, cs} <= dir_q ? cnt_dn : cnt_up;
      end
      if (lap_act) begin
        if (state == S_RUN) begin
          freeze <= ~freeze;
          if (!freeze) snap <= {mins, sec, cs};
        end else begin
          freeze <= 1'b0;
        end
      end
      if (expire) freeze <= 1'b0;
    end
  end

  assign shown = freeze ? snap : {mins, sec, cs};

  always_ff @(posedge clk) begin
    if (clr) begin
      HEX0 <= seg7(4'd0);
      HEX1 <= seg7(4'd0);
      HEX2 <= seg7(4'd0);
      HEX3 <= seg7(4'd0);
      HEX4 <= seg7(4'd0);
      HEX5 <= seg7(4'd0);
    end else begin
      HEX0 <= seg7(shown[3:0]);
      HEX1 <= seg7(shown[7:4]);
      HEX2 <= seg7(shown[11:8]);
      HEX3 <= seg7(shown[15:12]);
      HEX4 <= seg7(shown[19:16]);
      HEX5 <= seg7(shown[23:20]);
    end
  end
endmodule
